// File: rtl/bit_combiner.sv
// bit_combiner: re-interleaves an even/odd word pair into one LSB-first serial stream.
// Define BIT_COMBINER_PARITY_EN to append an even-parity beat to every frame.
module bit_combiner #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] dataeven,
    input  logic [W-1:0] dataodd,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         sout_last
);
    localparam int unsigned CW = $clog2(2 * W + 1);
`ifdef BIT_COMBINER_PARITY_EN
    localparam logic [CW-1:0] LastIdx = CW'(2 * W);
`else
    localparam logic [CW-1:0] LastIdx = CW'(2 * W - 1);
`endif

    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

    state_e        state_q;
    logic [W-1:0]  even_q;
    logic [W-1:0]  odd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          sout_q;
    logic          sout_valid_q;
    logic          sout_last_q;
    logic          beat;
    logic          load;
    logic          nxt_bit;

    assign beat     = sout_valid_q && sout_ready;
    assign in_ready = reset && (state_q == StIdle || (beat && sout_last_q));
    assign load     = in_valid && in_ready;
    assign cnt_nxt  = cnt_q + 1'b1;

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;

    // Bit shown after the current beat: even word on even counts, odd word on odd counts.
    always_comb begin
        nxt_bit = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (32'(cnt_nxt[CW-1:1]) == i) begin
                nxt_bit = cnt_nxt[0] ? odd_q[i] : even_q[i];
            end
        end
`ifdef BIT_COMBINER_PARITY_EN
        if (cnt_nxt == LastIdx) begin
            nxt_bit = ^{even_q, odd_q};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            even_q       <= '0;
            odd_q        <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else if (load) begin
            state_q      <= StShift;
            even_q       <= dataeven;
            odd_q        <= dataodd;
            cnt_q        <= '0;
            sout_q       <= dataeven[0];
            sout_valid_q <= 1'b1;
            sout_last_q  <= 1'b0;
        end else if (beat) begin
            if (sout_last_q) begin
                state_q      <= StIdle;
                sout_q       <= 1'b0;
                sout_valid_q <= 1'b0;
                sout_last_q  <= 1'b0;
            end else begin
                cnt_q       <= cnt_nxt;
                sout_q      <= nxt_bit;
                sout_last_q <= (cnt_nxt == LastIdx);
`ifdef BIT_COMBINER_PARITY_EN
                state_q     <= (cnt_nxt == LastIdx) ? StParity : StShift;
`else
                state_q     <= StShift;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bit_combiner.sv
// Self-checking bench for bit_combiner: directed frames plus randomized traffic against a
// bit-queue reference model.
module tb_bit_combiner;
    localparam int unsigned W = 4;
`ifdef BIT_COMBINER_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif
    localparam int FL = 2 * W + (Par ? 1 : 0);

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dataeven;
    logic [W-1:0] dataodd;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready;
    logic         sout_last;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats still owed by the DUT, each {last, data}.
    bit [1:0] exp_q[$];

    bit_combiner #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataeven  (dataeven),
        .dataodd   (dataodd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sout_ready(sout_ready),
        .sout_last (sout_last)
    );

    always #5 clk = ~clk;

    task automatic model_load(input logic [W-1:0] e, input logic [W-1:0] o);
        bit b;
        bit p;
        p = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            b = (k % 2 == 0) ? e[k/2] : o[k/2];
            p ^= b;
            exp_q.push_back({(k == 2 * W - 1) && !Par, b});
        end
        if (Par) exp_q.push_back({1'b1, p});
    endtask

    // Advances the model across the coming rising edge given the inputs now applied.
    task automatic model_step(output bit ld);
        bit rdy;
        rdy = reset && (exp_q.size() == 0 || (exp_q.size() == 1 && sout_ready));
        ld  = in_valid && rdy;
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && sout_ready) void'(exp_q.pop_front());
            if (ld) model_load(dataeven, dataodd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; sout_ready = 1'b1;
        dataeven = W'($urandom); dataodd = W'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({sout_valid, in_ready, sout, sout_last} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outputs cyc %0d: valid/ready/sout/last got %b want 0000",
                         c, {sout_valid, in_ready, sout, sout_last});
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || sout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready %b valid %b want 1 0", in_ready, sout_valid);
        end
    endtask

    task automatic test_single();
        bit expb [0:8] = '{0, 0, 1, 1, 0, 1, 1, 0, 0};
        @(posedge clk); #1;
        dataeven = 4'b1010; dataodd = 4'b0110; in_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_load_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int b = 0; b < FL; b++) begin
            @(negedge clk);
            n_cmp++;
            if ({sout_valid, sout, sout_last, in_ready} !== {1'b1, expb[b], b == FL - 1, b == FL - 1})
            begin
                n_bad++;
                $display("FAIL single_beat %0d: valid/sout/last/ready got %b want %b", b,
                         {sout_valid, sout, sout_last, in_ready},
                         {1'b1, expb[b], b == FL - 1, b == FL - 1});
            end
        end
        @(negedge clk);
        n_cmp++;
        if (sout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end_valid: got %b want 0", sout_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int left = 3;
        int n_valid = 0;
        int first_c = -1;
        int last_c = -1;
        bit ld;
        @(posedge clk); #1;
        in_valid = 1'b1; sout_ready = 1'b1;
        dataeven = W'($urandom); dataodd = W'($urandom);
        for (int c = 0; c < 3 * FL + 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sout_valid !== (exp_q.size() != 0)) begin
                n_bad++;
                $display("FAIL b2b_valid cyc %0d: got %b want %b", c, sout_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({sout_last, sout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL b2b_bit cyc %0d: last/sout got %b want %b", c,
                             {sout_last, sout}, exp_q[0]);
                end
            end
            n_cmp++;
            if (in_ready !== (exp_q.size() == 0 || exp_q.size() == 1)) begin
                n_bad++;
                $display("FAIL b2b_ready cyc %0d: got %b", c, in_ready);
            end
            if (sout_valid) begin
                n_valid++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            model_step(ld);
            @(posedge clk); #1;
            if (ld) begin
                left--;
                if (left == 0) in_valid = 1'b0;
                else begin
                    dataeven = W'($urandom); dataodd = W'($urandom);
                end
            end
        end
        n_cmp++;
        if (n_valid != 3 * FL || last_c - first_c + 1 != 3 * FL) begin
            n_bad++;
            $display("FAIL b2b_gapless: %0d valid over span %0d want %0d", n_valid,
                     last_c - first_c + 1, 3 * FL);
        end
    endtask

    task automatic test_backpressure();
        int n_valid = 0;
        int left = 6;
        bit frozen = 1'b0;
        bit done = 1'b0;
        bit ld;
        // Directed: three stalled cycles while bit 3 is on the line.
        @(posedge clk); #1;
        dataeven = 4'b1010; dataodd = 4'b0110; in_valid = 1'b1; sout_ready = 1'b1;
        for (int c = 0; c < FL + 6; c++) begin
            @(negedge clk);
            if (c == 4) frozen = sout;
            if (c >= 5 && c <= 7) begin
                n_cmp++;
                if (sout_valid !== 1'b1 || sout !== frozen) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc %0d: valid %b sout %b want 1 %b", c,
                             sout_valid, sout, frozen);
                end
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({sout_last, sout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL stall_bit cyc %0d: last/sout got %b want %b", c,
                             {sout_last, sout}, exp_q[0]);
                end
            end
            if (sout_valid) n_valid++;
            model_step(ld);
            @(posedge clk); #1;
            if (ld) in_valid = 1'b0;
            sout_ready = !(c + 1 >= 4 && c + 1 <= 6);
        end
        n_cmp++;
        if (n_valid != FL + 3) begin
            n_bad++;
            $display("FAIL stall_frame_len: got %0d cycles want %0d", n_valid, FL + 3);
        end
        // Randomized: bursty source and random downstream stalls.
        dataeven = W'($urandom); dataodd = W'($urandom); in_valid = 1'b1;
        for (int c = 0; c < 800 && !done; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sout_valid !== (exp_q.size() != 0)) begin
                n_bad++;
                $display("FAIL rand_valid cyc %0d: got %b want %b", c, sout_valid,
                         exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({sout_last, sout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL rand_bit cyc %0d: last/sout got %b want %b", c,
                             {sout_last, sout}, exp_q[0]);
                end
            end
            n_cmp++;
            if (in_ready !== (exp_q.size() == 0 || (exp_q.size() == 1 && sout_ready))) begin
                n_bad++;
                $display("FAIL rand_ready cyc %0d: got %b", c, in_ready);
            end
            if (left == 0 && exp_q.size() == 0) done = 1'b1;
            model_step(ld);
            @(posedge clk); #1;
            if (ld) begin
                left--;
                dataeven = W'($urandom); dataodd = W'($urandom);
            end
            in_valid   = (left > 0) && ($urandom_range(0, 2) != 0);
            sout_ready = (left == 0) || ($urandom_range(0, 3) != 0);
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL rand_timeout: %0d frames outstanding, %0d beats queued", left,
                     exp_q.size());
        end
        in_valid = 1'b0; sout_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int phase = 0;
        int beats = 0;
        int hold = 0;
        bit ld;
        bit [W-1:0] b_even;
        @(posedge clk); #1;
        dataeven = W'($urandom); dataodd = W'($urandom); in_valid = 1'b1; sout_ready = 1'b1;
        b_even = W'($urandom);
        for (int c = 0; c < 60 && phase < 5; c++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({sout_last, sout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL rmid_bit cyc %0d: last/sout got %b want %b", c,
                             {sout_last, sout}, exp_q[0]);
                end
            end
            if (phase == 2 && hold == 1) begin
                n_cmp++;
                if (sout_valid !== 1'b0 || in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rmid_discard: valid %b ready %b want 0 0", sout_valid, in_ready);
                end
            end
            if (phase == 4 && beats == 0) begin
                n_cmp++;
                if (sout_valid !== 1'b1 || sout !== b_even[0]) begin
                    n_bad++;
                    $display("FAIL rmid_restart: valid %b sout %b want 1 %b", sout_valid, sout,
                             b_even[0]);
                end
            end
            if (sout_valid && sout_ready) beats++;
            if (phase == 4 && exp_q.size() == 1) phase = 5;
            model_step(ld);
            @(posedge clk); #1;
            case (phase)
                0: if (ld) begin in_valid = 1'b0; phase = 1; beats = 0; end
                1: if (beats == 4) begin reset = 1'b0; phase = 2; hold = 0; end
                2: begin
                    hold++;
                    if (hold == 2) begin
                        reset = 1'b1; in_valid = 1'b1; dataeven = b_even; phase = 3;
                    end
                end
                3: if (ld) begin in_valid = 1'b0; phase = 4; beats = 0; end
                default: ;
            endcase
        end
        n_cmp++;
        if (phase != 5) begin
            n_bad++;
            $display("FAIL rmid_timeout: stuck in phase %0d", phase);
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

`ifdef BIT_COMBINER_PARITY_EN
    task automatic test_parity();
        bit ld;
        int b = 0;
        @(posedge clk); #1;
        dataeven = 4'b0001; dataodd = 4'b0000; in_valid = 1'b1; sout_ready = 1'b1;
        for (int c = 0; c < FL + 3; c++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({sout_last, sout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL par_bit cyc %0d: last/sout got %b want %b", c,
                             {sout_last, sout}, exp_q[0]);
                end
                b++;
                if (b == FL) begin
                    n_cmp++;
                    if ({sout_last, sout} !== 2'b11) begin
                        n_bad++;
                        $display("FAIL par_beat: last/sout got %b want 11", {sout_last, sout});
                    end
                end
            end
            model_step(ld);
            @(posedge clk); #1;
            if (ld) in_valid = 1'b0;
        end
    endtask
`endif

    initial begin
        reset = 1'b0; in_valid = 1'b0; sout_ready = 1'b1; dataeven = '0; dataodd = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef BIT_COMBINER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
